// File: rtl/gate_array_pkg.sv
// Shared types, default dimensions and the per-bit 4-state gate function for gate_array_pipe.
package gate_array_pkg;

   typedef enum logic [1:0] {GA_AND, GA_OR, GA_XOR, GA_WAND} ga_mode_e;

   localparam int unsigned GA_CHANNELS = 3;
   localparam int unsigned GA_LANES    = 3;
   localparam int unsigned GA_WIDTH    = 5;
   localparam int unsigned GA_DEPTH    = 2;
   localparam int unsigned GA_CNT_W    = 16;

   // Wired-AND treats Z as "not driving", so the other side wins; Z on both sides stays Z.
   function automatic logic ga_bit(ga_mode_e m, logic x, logic z_in);
      logic r;
      r = 1'bx;
      case (m)
         GA_AND:  r = x & z_in;
         GA_OR:   r = x | z_in;
         GA_XOR:  r = x ^ z_in;
         GA_WAND: begin
            if (x === 1'bz && z_in === 1'bz) r = 1'bz;
            else if (x === 1'bz)             r = z_in;
            else if (z_in === 1'bz)          r = x;
            else                             r = x & z_in;
         end
         default: r = 1'bx;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ga_fifo.sv
// Generic valid/ready FIFO; an occupancy counter separates full from empty, and the head
// reads as zero whenever the FIFO is empty.
module ga_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter type         T     = logic
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   T                 mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             full, push, pop;

   function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full      = (occ_q == OCC_W'(DEPTH));
   assign out_valid = (occ_q != '0);
   // A pop frees a slot in the same cycle, so a full FIFO can still accept.
   assign in_ready  = !full | (out_valid & out_ready);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = out_valid ? mem_q[rptr_q] : '0;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      if (push) wptr_d = next_ptr(wptr_q);
      if (pop)  rptr_d = next_ptr(rptr_q);
      case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         occ_q  <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= in_data;
   end

endmodule

// File: rtl/gate_array_pipe.sv
// Multi-channel 4-state bitwise gate array with X/Z sanitising to 2-state, per-channel X/Z
// flags, a saturating X/Z beat counter and a registered valid/ready output FIFO.
module gate_array_pipe
   import gate_array_pkg::*;
#(
   parameter int unsigned CHANNELS = GA_CHANNELS,
   parameter int unsigned LANES    = GA_LANES,
   parameter int unsigned WIDTH    = GA_WIDTH,
   parameter int unsigned DEPTH    = GA_DEPTH,
   parameter bit          XZ_FILL  = 1'b0,
   parameter int unsigned CNT_W    = GA_CNT_W
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [1:0]                                mode,
   input  logic [CHANNELS-1:0][LANES-1:0][WIDTH-1:0] a,
   input  logic [CHANNELS-1:0][LANES-1:0][WIDTH-1:0] b,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output bit   [CHANNELS-1:0][LANES-1:0][WIDTH-1:0] y,
   output logic [CHANNELS-1:0]                       xz_flag,
   output logic [CNT_W-1:0]                          xz_count,
   input  logic                                      cnt_clr
);

   localparam int unsigned LW = LANES * WIDTH;
   localparam int unsigned NB = CHANNELS * LW;
   localparam int unsigned PW = NB + CHANNELS;

   logic [CHANNELS-1:0][LANES-1:0][WIDTH-1:0] raw;
   bit   [CHANNELS-1:0][LANES-1:0][WIDTH-1:0] clean;
   logic [CHANNELS-1:0][LW-1:0]               xz_bit;
   logic [CHANNELS-1:0]                       beat_flag;
   logic [PW-1:0]                             push_data, head_data;
   logic [CNT_W-1:0]                          xz_count_q, xz_count_d;
   ga_mode_e                                  mode_e;
   logic                                      push;

   assign mode_e = ga_mode_e'(mode);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         for (genvar w = 0; w < WIDTH; w++) begin : g_bit
            assign raw[c][l][w]             = ga_bit(mode_e, a[c][l][w], b[c][l][w]);
            assign xz_bit[c][l*WIDTH + w]   = $isunknown(raw[c][l][w]);
            assign clean[c][l][w]           = xz_bit[c][l*WIDTH + w] ? XZ_FILL : raw[c][l][w];
         end
      end
      assign beat_flag[c] = |xz_bit[c];
   end

   assign push_data = {clean, beat_flag};

   ga_fifo #(
      .DEPTH (DEPTH),
      .T     (logic [PW-1:0])
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (push_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head_data)
   );

   assign y       = head_data[PW-1:CHANNELS];
   assign xz_flag = head_data[CHANNELS-1:0];
   assign push    = in_valid & in_ready;

   // Clear wins over a coincident increment; the count sticks at all-ones.
   always_comb begin
      xz_count_d = xz_count_q;
      if (cnt_clr) begin
         xz_count_d = '0;
      end else if (push && (|beat_flag) && (xz_count_q != '1)) begin
         xz_count_d = xz_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) xz_count_q <= '0;
      else        xz_count_q <= xz_count_d;
   end

   assign xz_count = xz_count_q;

endmodule

// File: tb/tb_gate_array_pipe.sv
// Self-checking bench for gate_array_pipe: directed and random beats against a queue-based
// reference model computed from 4-state operator tables.
module tb_gate_array_pipe;

   localparam int C  = 3;
   localparam int L  = 3;
   localparam int W  = 5;
   localparam int D  = 2;
   localparam int CW = 4;
   localparam int N  = C * L * W;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid, out_ready, cnt_clr;
   logic [1:0] mode;
   logic [C-1:0][L-1:0][W-1:0] a, b;
   logic in_ready, out_valid;
   bit   [C-1:0][L-1:0][W-1:0] y;
   logic [C-1:0] xz_flag;
   logic [CW-1:0] xz_count;

   typedef struct packed {
      logic [N-1:0] y;
      logic [C-1:0] f;
   } exp_t;

   exp_t q[$];
   int   cnt_m  = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   gate_array_pipe #(
      .CHANNELS (C),
      .LANES    (L),
      .WIDTH    (W),
      .DEPTH    (D),
      .XZ_FILL  (1'b0),
      .CNT_W    (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .xz_flag   (xz_flag),
      .xz_count  (xz_count),
      .cnt_clr   (cnt_clr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] m, input logic [N-1:0] av,
                                  input logic [N-1:0] bv);
      logic [N-1:0] r;
      exp_t e;
      case (m)
         2'd0:    r = av & bv;
         2'd1:    r = av | bv;
         2'd2:    r = av ^ bv;
         default: for (int i = 0; i < N; i++)
                     r[i] = (av[i] === 1'bz) ? bv[i] : (bv[i] === 1'bz) ? av[i] : (av[i] & bv[i]);
      endcase
      e = '0;
      for (int i = 0; i < N; i++) begin
         if ($isunknown(r[i])) begin
            e.y[i] = 1'b0;
            e.f[i / (L * W)] = 1'b1;
         end else begin
            e.y[i] = r[i];
         end
      end
      return e;
   endfunction

   function automatic logic [N-1:0] rnd(input bit xz);
      logic [N-1:0] v;
      v = N'({$urandom(), $urandom()});
      if (xz) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 9) == 0) v[i] = $urandom_range(0, 1) ? 1'bx : 1'bz;
      end
      return v;
   endfunction

   // One clock: drive at negedge, compare outputs against the model, then advance the model.
   task automatic step(input logic iv, input logic ordy, input logic clr, input logic [1:0] m,
                       input logic [N-1:0] av, input logic [N-1:0] bv, output logic acc);
      exp_t e;
      logic exp_ov, exp_ir;
      @(negedge clk);
      in_valid  = iv;
      out_ready = ordy;
      cnt_clr   = clr;
      mode      = m;
      a         = av;
      b         = bv;
      #1;
      exp_ov = (q.size() != 0);
      exp_ir = (q.size() < D) || (exp_ov && ordy);
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      chk("y", 64'(y), 64'(exp_ov ? q[0].y : N'(0)));
      chk("xz_flag", 64'(xz_flag), 64'(exp_ov ? q[0].f : C'(0)));
      chk("xz_count", 64'(xz_count), 64'(cnt_m));
      @(posedge clk);
      acc = iv && exp_ir;
      e   = model(m, av, bv);
      if (exp_ov && ordy) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (clr) cnt_m = 0;
      else if (acc && (e.f != '0) && (cnt_m < CMAX)) cnt_m++;
   endtask

   initial begin
      logic acc, iv, hold;
      logic [1:0] hm;
      logic [N-1:0] ha, hb;
      logic [C-1:0][L-1:0][W-1:0] ta, tb2;

      in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0; mode = 2'd0; a = '0; b = '0;
      rst_n = 1'b0;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_y", 64'(y), 64'(0));
      chk("rst_xz_count", 64'(xz_count), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // AND of all ones
      step(1'b1, 1'b1, 1'b0, 2'd0, '1, '1, acc);
      step(1'b0, 1'b1, 1'b0, 2'd0, '0, '0, acc);

      // Wired-AND with Z/X on channel 1 lane 0
      ta = '1; ta[1][0] = 5'bz1x1z;
      tb2 = '1; tb2[1][0] = 5'b10101;
      step(1'b1, 1'b1, 1'b0, 2'd3, ta, tb2, acc);
      step(1'b0, 1'b1, 1'b0, 2'd0, '0, '0, acc);

      // Backpressure: third beat must wait until the consumer pops
      for (int k = 0; k < 3; k++) begin
         ha = rnd(1'b0); hb = rnd(1'b0); hm = 2'($urandom_range(0, 3));
         acc = 1'b0;
         for (int t = 0; t < 6 && !acc; t++) step(1'b1, t >= 3, 1'b0, hm, ha, hb, acc);
         chk("bp_accept", 64'(acc), 64'(1));
      end
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 2'd0, '0, '0, acc);

      // Fill, then push and pop together across pointer wrap
      step(1'b1, 1'b0, 1'b0, 2'd1, rnd(1'b0), rnd(1'b0), acc);
      step(1'b1, 1'b0, 1'b0, 2'd2, rnd(1'b0), rnd(1'b0), acc);
      for (int k = 0; k < 10; k++)
         step(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)), rnd(1'b0), rnd(1'b0), acc);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 2'd0, '0, '0, acc);

      // X-bearing beats drive the counter to saturation, then clear beats a coincident increment
      for (int k = 0; k < 20; k++) begin
         ha = rnd(1'b0); ha[$urandom_range(0, N - 1)] = 1'bx;
         step(1'b1, 1'b1, 1'b0, 2'd0, ha, '1, acc);
      end
      ha = rnd(1'b0); ha[0] = 1'bx;
      step(1'b1, 1'b1, 1'b1, 2'd0, ha, '1, acc);
      step(1'b0, 1'b1, 1'b0, 2'd0, '0, '0, acc);

      // Random traffic; an offered beat is held until accepted
      hold = 1'b0; iv = 1'b0; hm = 2'd0; ha = '0; hb = '0;
      for (int k = 0; k < 120; k++) begin
         if (!hold) begin
            iv = ($urandom_range(0, 3) != 0);
            hm = 2'($urandom_range(0, 3));
            ha = rnd(1'b1);
            hb = rnd(1'b1);
         end
         step(iv, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, hm, ha, hb, acc);
         hold = iv && !acc;
      end

      // Reset mid-stream with two beats queued
      step(1'b1, 1'b0, 1'b0, 2'd3, rnd(1'b1), rnd(1'b1), acc);
      step(1'b1, 1'b0, 1'b0, 2'd0, rnd(1'b1), rnd(1'b1), acc);
      chk("queued_before_reset", 64'(q.size()), 64'(2));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", 64'(out_valid), 64'(0));
      chk("async_y", 64'(y), 64'(0));
      chk("async_xz_flag", 64'(xz_flag), 64'(0));
      chk("async_xz_count", 64'(xz_count), 64'(0));
      q.delete();
      cnt_m = 0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b1, 1'b0, 2'd1, rnd(1'b1), rnd(1'b1), acc);
      step(1'b0, 1'b1, 1'b0, 2'd0, '0, '0, acc);
      step(1'b0, 1'b1, 1'b0, 2'd0, '0, '0, acc);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
